ktms_afu_put_resp: RTL and testbench

Responder end of the AFU put (DMA write) channel. Accepts one put address and a two-beat parity-protected data burst per transaction. Checks address and data parity, then issues one 32-byte write to the host write port. Returns exactly one put_done with a completion code per accepted address. Sits between put initiators (status/IOASA writers) and the host command/write interface.

---
 rtl/ktms_afu_put_resp.sv | 211 +++++++++++++++++++++
 tb/tb_ktms_afu_put_resp.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ktms_afu_put_resp.sv
`default_nettype none
// ============================================================================
// Module   : ktms_afu_put_resp
// Brief    : AFU put responder; parity-checks one address plus a two-beat burst,
//            issues a single 32-byte host write and returns put_done with an rc.
//            Optional write-response timeout: define KTMS_PUT_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module ktms_afu_put_resp #(
    parameter int CTXTID_WIDTH = 10,
    parameter int EA_WIDTH     = 65,
    parameter int TSTAG_WIDTH  = 1,
    parameter int DMA_RC_WIDTH = 8,
    parameter logic [DMA_RC_WIDTH-1:0] RC_PERR  = 8'h0f,
    parameter logic [DMA_RC_WIDTH-1:0] RC_PROTO = 8'h0e,
    parameter logic [DMA_RC_WIDTH-1:0] RC_TMO   = 8'h0d,
    parameter int TMO_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_put_addr_v,
    output logic                    i_put_addr_r,
    input  logic [EA_WIDTH-1:0]     i_put_addr_ea,
    input  logic [CTXTID_WIDTH-1:0] i_put_addr_ctxt,
    input  logic [TSTAG_WIDTH-1:0]  i_put_addr_tstag,
    input  logic                    i_put_data_v,
    output logic                    i_put_data_r,
    input  logic [129:0]            i_put_data_d,
    input  logic [3:0]              i_put_data_c,
    input  logic                    i_put_data_f,
    input  logic                    i_put_data_e,
    output logic                    o_put_done_v,
    input  logic                    o_put_done_r,
    output logic [DMA_RC_WIDTH-1:0] o_put_done_rc,
    output logic                    o_wr_v,
    input  logic                    o_wr_r,
    output logic [63:0]             o_wr_ea,
    output logic [CTXTID_WIDTH-1:0] o_wr_ctxt,
    output logic [TSTAG_WIDTH-1:0]  o_wr_tstag,
    output logic [255:0]            o_wr_d,
    input  logic                    i_wrsp_v,
    input  logic [DMA_RC_WIDTH-1:0] i_wrsp_rc,
    output logic                    o_perror,
    output logic                    o_busy
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_data = 3'd1;
    localparam logic [2:0] c_st_cmd  = 3'd2;
    localparam logic [2:0] c_st_wait = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic                    r_live;
    logic [1:0]              r_beat;
    logic                    r_perr;
    logic                    r_proto;
    logic                    r_perror;
    logic [63:0]             r_ea;
    logic [CTXTID_WIDTH-1:0] r_ctxt;
    logic [TSTAG_WIDTH-1:0]  r_tstag;
    logic [255:0]            r_d;
    logic [DMA_RC_WIDTH-1:0] r_wrsp_rc;
    logic                    w_tmo_hit;
    logic                    w_tmo_err;

    wire w_addr_hs = i_put_addr_v & i_put_addr_r;
    wire w_data_hs = i_put_data_v & i_put_data_r;
    wire w_wr_hs   = o_wr_v & o_wr_r;
    wire w_done_hs = o_put_done_v & o_put_done_r;
    wire w_unused  = &{1'b0, i_put_data_c, i_put_data_f};

    // Odd parity: a clean word XORs to 1 including its parity bit.
    wire w_ea_perr = ~(^i_put_addr_ea);
    wire w_d_perr  = ~(^{i_put_data_d[63:0], i_put_data_d[128]}) |
                     ~(^{i_put_data_d[127:64], i_put_data_d[129]});
    wire w_beat_proto = (r_beat == 2'd0) ? i_put_data_e
                                         : ((r_beat == 2'd1) && !i_put_data_e);
    wire w_err_at_end = r_perr | r_proto | w_d_perr | w_beat_proto;

`ifdef KTMS_PUT_TIMEOUT_EN
    localparam logic [TMO_WIDTH-1:0] c_tmo_last = {{(TMO_WIDTH-1){1'b1}}, 1'b0};
    logic [TMO_WIDTH-1:0] r_tmo;
    logic                 r_tmo_err;

    // Leaving WAIT on the edge the counter turns all-ones.
    assign w_tmo_hit = (r_state == c_st_wait) && !i_wrsp_v && (r_tmo == c_tmo_last);
    assign w_tmo_err = r_tmo_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo     <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (w_wr_hs)
                r_tmo <= '0;
            else if (r_state == c_st_wait)
                r_tmo <= r_tmo + 1'b1;
            if (w_tmo_hit)
                r_tmo_err <= 1'b1;
            else if (w_done_hs)
                r_tmo_err <= 1'b0;
        end
    end
`else
    wire [TMO_WIDTH-1:0] w_unused_tmo = '0;
    assign w_tmo_hit = 1'b0;
    assign w_tmo_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= c_st_idle;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_addr_hs) w_state_nxt = c_st_data;
            c_st_data: if (w_data_hs && i_put_data_e)
                           w_state_nxt = w_err_at_end ? c_st_done : c_st_cmd;
            c_st_cmd:  if (w_wr_hs) w_state_nxt = c_st_wait;
            c_st_wait: if (i_wrsp_v || w_tmo_hit) w_state_nxt = c_st_done;
            c_st_done: if (w_done_hs) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        i_put_addr_r  = 1'b0;
        i_put_data_r  = 1'b0;
        o_wr_v        = 1'b0;
        o_put_done_v  = 1'b0;
        o_put_done_rc = '0;
        case (r_state)
            c_st_idle: i_put_addr_r = r_live;
            c_st_data: i_put_data_r = 1'b1;
            c_st_cmd:  o_wr_v = 1'b1;
            c_st_done: begin
                o_put_done_v = 1'b1;
                if (r_perr)
                    o_put_done_rc = RC_PERR;
                else if (r_proto)
                    o_put_done_rc = RC_PROTO;
                else if (w_tmo_err)
                    o_put_done_rc = RC_TMO;
                else
                    o_put_done_rc = r_wrsp_rc;
            end
            default: ;
        endcase
    end

    // r_live holds address-ready low while reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live    <= 1'b0;
            r_beat    <= 2'd0;
            r_perr    <= 1'b0;
            r_proto   <= 1'b0;
            r_perror  <= 1'b0;
            r_ea      <= '0;
            r_ctxt    <= '0;
            r_tstag   <= '0;
            r_d       <= '0;
            r_wrsp_rc <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_addr_hs) begin
                r_ea    <= i_put_addr_ea[63:0];
                r_ctxt  <= i_put_addr_ctxt;
                r_tstag <= i_put_addr_tstag;
                r_perr  <= w_ea_perr;
                r_proto <= 1'b0;
                r_beat  <= 2'd0;
            end
            if (w_data_hs) begin
                if (r_beat == 2'd0)
                    r_d[127:0] <= i_put_data_d[127:0];
                if (r_beat == 2'd1)
                    r_d[255:128] <= i_put_data_d[127:0];
                if (r_beat != 2'd2)
                    r_beat <= r_beat + 2'd1;
                if (w_d_perr)
                    r_perr <= 1'b1;
                if (w_beat_proto)
                    r_proto <= 1'b1;
            end
            if ((w_addr_hs && w_ea_perr) || (w_data_hs && w_d_perr))
                r_perror <= 1'b1;
            if ((r_state == c_st_wait) && i_wrsp_v)
                r_wrsp_rc <= i_wrsp_rc;
            if (w_done_hs) begin
                r_perr  <= 1'b0;
                r_proto <= 1'b0;
            end
        end
    end

    assign o_wr_ea    = r_ea;
    assign o_wr_ctxt  = r_ctxt;
    assign o_wr_tstag = r_tstag;
    assign o_wr_d     = r_d;
    assign o_perror   = r_perror;
    assign o_busy     = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_ktms_afu_put_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ktms_afu_put_resp
// Brief    : Scoreboard bench for ktms_afu_put_resp (timeout cases need
//            KTMS_PUT_TIMEOUT_EN, which also shrinks the counter to 4 bits).
// Revision : 1.0
// ============================================================================
module tb_ktms_afu_put_resp;

`ifdef KTMS_PUT_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 16;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         i_put_addr_v = 1'b0;
    logic         i_put_addr_r;
    logic [64:0]  i_put_addr_ea = '0;
    logic [9:0]   i_put_addr_ctxt = '0;
    logic [0:0]   i_put_addr_tstag = '0;
    logic         i_put_data_v = 1'b0;
    logic         i_put_data_r;
    logic [129:0] i_put_data_d = '0;
    logic [3:0]   i_put_data_c = '0;
    logic         i_put_data_f = 1'b0;
    logic         i_put_data_e = 1'b0;
    logic         o_put_done_v;
    logic         o_put_done_r = 1'b1;
    logic [7:0]   o_put_done_rc;
    logic         o_wr_v;
    logic         o_wr_r = 1'b1;
    logic [63:0]  o_wr_ea;
    logic [9:0]   o_wr_ctxt;
    logic [0:0]   o_wr_tstag;
    logic [255:0] o_wr_d;
    logic         i_wrsp_v = 1'b0;
    logic [7:0]   i_wrsp_rc = '0;
    logic         o_perror;
    logic         o_busy;

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    int exp_wr_count = 0;

    logic [7:0]   exp_rc[$];
    logic [255:0] exp_d[$];
    logic [63:0]  exp_ea[$];

    ktms_afu_put_resp #(.TMO_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .i_put_addr_v(i_put_addr_v), .i_put_addr_r(i_put_addr_r),
        .i_put_addr_ea(i_put_addr_ea), .i_put_addr_ctxt(i_put_addr_ctxt),
        .i_put_addr_tstag(i_put_addr_tstag),
        .i_put_data_v(i_put_data_v), .i_put_data_r(i_put_data_r),
        .i_put_data_d(i_put_data_d), .i_put_data_c(i_put_data_c),
        .i_put_data_f(i_put_data_f), .i_put_data_e(i_put_data_e),
        .o_put_done_v(o_put_done_v), .o_put_done_r(o_put_done_r),
        .o_put_done_rc(o_put_done_rc),
        .o_wr_v(o_wr_v), .o_wr_r(o_wr_r), .o_wr_ea(o_wr_ea),
        .o_wr_ctxt(o_wr_ctxt), .o_wr_tstag(o_wr_tstag), .o_wr_d(o_wr_d),
        .i_wrsp_v(i_wrsp_v), .i_wrsp_rc(i_wrsp_rc),
        .o_perror(o_perror), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_wr_v && o_wr_r) wr_count++;

    localparam logic [127:0] D_A = {32{4'hA}};
    localparam logic [127:0] D_5 = {32{4'h5}};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addr(input logic [63:0] ea, input logic [9:0] ctxt,
                              input logic tstag, input logic corrupt);
        logic got;
        got = 1'b0;
        i_put_addr_ea    = {(~(^ea)) ^ corrupt, ea};
        i_put_addr_ctxt  = ctxt;
        i_put_addr_tstag = tstag;
        i_put_addr_v     = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = i_put_addr_r;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL addr_ready_timeout: ready=%0b required=1", got);
        end
        tick();
        i_put_addr_v = 1'b0;
    endtask

    task automatic drive_beat(input logic [127:0] d, input logic e, input logic flip);
        logic got;
        got = 1'b0;
        i_put_data_d = {~(^d[127:64]), (~(^d[63:0])) ^ flip, d};
        i_put_data_e = e;
        i_put_data_v = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = i_put_data_r;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL data_ready_timeout: ready=%0b required=1", got);
        end
        tick();
        i_put_data_v = 1'b0;
        i_put_data_e = 1'b0;
    endtask

    // Stimulus plus observation only; each test judges what came back.
    task automatic run_txn(input logic [63:0] ea, input logic [9:0] ctxt, input logic tstag,
                           input logic addr_bad, input logic [127:0] d0, input logic [127:0] d1,
                           input int nbeats, input int flip_beat, input logic reply,
                           input logic [7:0] host_rc,
                           output logic wr_seen, output logic [63:0] wr_ea,
                           output logic [255:0] wr_d, output logic [10:0] wr_tag,
                           output int wr_cyc, output logic done_seen,
                           output logic [7:0] done_rc, output int done_cyc);
        logic reply_now;
        logic [127:0] bd;
        wr_seen = 1'b0; wr_ea = '0; wr_d = '0; wr_tag = '0; wr_cyc = 0;
        done_seen = 1'b0; done_rc = '0; done_cyc = 0; reply_now = 1'b0;
        drive_addr(ea, ctxt, tstag, addr_bad);
        for (int i = 0; i < nbeats; i++) begin
            bd = (i == 0) ? d0 : (i == 1) ? d1 : {$urandom, $urandom, $urandom, $urandom};
            drive_beat(bd, i == nbeats - 1, i == flip_beat);
        end
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (o_put_done_v) begin
                done_seen = 1'b1;
                done_rc   = o_put_done_rc;
                done_cyc  = c;
                tick();
                break;
            end
            if (o_wr_v && !wr_seen) begin
                wr_seen   = 1'b1;
                wr_ea     = o_wr_ea;
                wr_d      = o_wr_d;
                wr_tag    = {o_wr_ctxt, o_wr_tstag};
                wr_cyc    = c;
                reply_now = reply;
            end
            tick();
            i_wrsp_v  = reply_now;
            i_wrsp_rc = reply_now ? host_rc : 8'h00;
            reply_now = 1'b0;
        end
    endtask

    logic         t_wr, t_done;
    logic [63:0]  t_ea;
    logic [255:0] t_d;
    logic [10:0]  t_tag;
    logic [7:0]   t_rc, e_rc;
    int           t_wcyc, t_dcyc;

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({i_put_addr_r, i_put_data_r, o_wr_v, o_put_done_v, o_perror, o_busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 000000",
                     {i_put_addr_r, i_put_data_r, o_wr_v, o_put_done_v, o_perror, o_busy});
        end
        total++;
        if (o_wr_ea !== 64'h0 || o_wr_d !== 256'h0 || o_put_done_rc !== 8'h0 ||
            o_wr_ctxt !== 10'h0 || o_wr_tstag !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: ea=%h rc=%h required 0", o_wr_ea, o_put_done_rc);
        end
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (i_put_addr_r !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: addr_r=%b busy=%b required 1 0", i_put_addr_r, o_busy);
        end
        tick();
    endtask

    task automatic test_good_write;
        exp_rc.push_back(8'h00);
        exp_ea.push_back(64'h1000);
        exp_d.push_back({D_5, D_A});
        exp_wr_count++;
        run_txn(64'h1000, 10'h2a5, 1'b1, 1'b0, D_A, D_5, 2, -1, 1'b1, 8'h00,
                t_wr, t_ea, t_d, t_tag, t_wcyc, t_done, t_rc, t_dcyc);
        total++;
        if (!t_wr || t_wcyc != 1) begin
            bad++;
            $display("FAIL good_wr_latency: seen=%b cycle=%0d required 1 1", t_wr, t_wcyc);
        end
        total++;
        if (t_ea !== exp_ea.pop_front()) begin
            bad++;
            $display("FAIL good_wr_ea: got %h required 1000", t_ea);
        end
        total++;
        if (t_d !== exp_d.pop_front() || t_tag !== {10'h2a5, 1'b1}) begin
            bad++;
            $display("FAIL good_wr_data: got %h tag %h", t_d, t_tag);
        end
        e_rc = exp_rc.pop_front();
        total++;
        if (!t_done || t_rc !== e_rc || t_dcyc - t_wcyc != 2) begin
            bad++;
            $display("FAIL good_done: seen=%b rc=%h gap=%0d required 1 %h 2",
                     t_done, t_rc, t_dcyc - t_wcyc, e_rc);
        end
        total++;
        if (o_perror !== 1'b0) begin
            bad++;
            $display("FAIL good_perror: got %b required 0", o_perror);
        end
    endtask

    task automatic test_data_parity;
        exp_rc.push_back(8'h0f);
        run_txn(64'h2000, 10'h011, 1'b0, 1'b0, D_A, D_5, 2, 1, 1'b1, 8'h00,
                t_wr, t_ea, t_d, t_tag, t_wcyc, t_done, t_rc, t_dcyc);
        e_rc = exp_rc.pop_front();
        total++;
        if (t_wr !== 1'b0 || !t_done || t_rc !== e_rc) begin
            bad++;
            $display("FAIL data_parity: wr=%b done=%b rc=%h required 0 1 %h", t_wr, t_done, t_rc, e_rc);
        end
        total++;
        if (o_perror !== 1'b1) begin
            bad++;
            $display("FAIL data_parity_flag: got %b required 1", o_perror);
        end
        exp_rc.push_back(8'h0f);
        run_txn(64'h2040, 10'h012, 1'b0, 1'b1, D_5, D_A, 2, -1, 1'b1, 8'h00,
                t_wr, t_ea, t_d, t_tag, t_wcyc, t_done, t_rc, t_dcyc);
        e_rc = exp_rc.pop_front();
        total++;
        if (t_wr !== 1'b0 || !t_done || t_rc !== e_rc) begin
            bad++;
            $display("FAIL addr_parity: wr=%b done=%b rc=%h required 0 1 %h", t_wr, t_done, t_rc, e_rc);
        end
    endtask

    task automatic test_perror_sticky;
        exp_rc.push_back(8'h00);
        exp_wr_count++;
        run_txn(64'h3000, 10'h003, 1'b0, 1'b0, D_5, D_A, 2, -1, 1'b1, 8'h00,
                t_wr, t_ea, t_d, t_tag, t_wcyc, t_done, t_rc, t_dcyc);
        e_rc = exp_rc.pop_front();
        total++;
        if (!t_wr || !t_done || t_rc !== e_rc || o_perror !== 1'b1) begin
            bad++;
            $display("FAIL perror_sticky: wr=%b rc=%h perror=%b required 1 %h 1", t_wr, t_rc, o_perror, e_rc);
        end
    endtask

    task automatic test_proto;
        exp_rc.push_back(8'h0e);
        run_txn(64'h4000, 10'h004, 1'b0, 1'b0, D_A, D_5, 1, -1, 1'b1, 8'h00,
                t_wr, t_ea, t_d, t_tag, t_wcyc, t_done, t_rc, t_dcyc);
        e_rc = exp_rc.pop_front();
        total++;
        if (t_wr !== 1'b0 || !t_done || t_rc !== e_rc) begin
            bad++;
            $display("FAIL proto_short: wr=%b rc=%h required 0 %h", t_wr, t_rc, e_rc);
        end
        exp_rc.push_back(8'h0e);
        run_txn(64'h4100, 10'h005, 1'b1, 1'b0, D_A, D_5, 3, -1, 1'b1, 8'h00,
                t_wr, t_ea, t_d, t_tag, t_wcyc, t_done, t_rc, t_dcyc);
        e_rc = exp_rc.pop_front();
        total++;
        if (t_wr !== 1'b0 || !t_done || t_rc !== e_rc) begin
            bad++;
            $display("FAIL proto_long: wr=%b rc=%h required 0 %h", t_wr, t_rc, e_rc);
        end
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || i_put_addr_r !== 1'b1) begin
            bad++;
            $display("FAIL proto_drained: busy=%b addr_r=%b required 0 1", o_busy, i_put_addr_r);
        end
        tick();
    endtask

    task automatic test_host_rc_backpressure;
        exp_rc.push_back(8'h05);
        exp_wr_count++;
        run_txn(64'h5000, 10'h006, 1'b0, 1'b0, D_A, D_A, 2, -1, 1'b1, 8'h05,
                t_wr, t_ea, t_d, t_tag, t_wcyc, t_done, t_rc, t_dcyc);
        e_rc = exp_rc.pop_front();
        total++;
        if (!t_wr || !t_done || t_rc !== e_rc) begin
            bad++;
            $display("FAIL host_rc: wr=%b rc=%h required 1 %h", t_wr, t_rc, e_rc);
        end
        o_put_done_r = 1'b0;
        exp_rc.push_back(8'h33);
        exp_wr_count++;
        run_txn(64'h5100, 10'h007, 1'b1, 1'b0, D_5, D_5, 2, -1, 1'b1, 8'h33,
                t_wr, t_ea, t_d, t_tag, t_wcyc, t_done, t_rc, t_dcyc);
        e_rc = exp_rc.pop_front();
        i_put_addr_v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (o_put_done_v !== 1'b1 || o_put_done_rc !== e_rc || i_put_addr_r !== 1'b0) begin
                bad++;
                $display("FAIL done_hold[%0d]: v=%b rc=%h addr_r=%b required 1 %h 0",
                         i, o_put_done_v, o_put_done_rc, i_put_addr_r, e_rc);
            end
            tick();
        end
        i_put_addr_v = 1'b0;
        o_put_done_r = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_put_done_v !== 1'b0) begin
            bad++;
            $display("FAIL done_release: busy=%b v=%b required 0 0", o_busy, o_put_done_v);
        end
        tick();
    endtask

`ifdef KTMS_PUT_TIMEOUT_EN
    task automatic test_timeout;
        exp_rc.push_back(8'h0d);
        exp_wr_count++;
        run_txn(64'h6000, 10'h008, 1'b0, 1'b0, D_A, D_5, 2, -1, 1'b0, 8'h00,
                t_wr, t_ea, t_d, t_tag, t_wcyc, t_done, t_rc, t_dcyc);
        e_rc = exp_rc.pop_front();
        total++;
        if (!t_wr || !t_done || t_rc !== e_rc || t_dcyc - t_wcyc != 16) begin
            bad++;
            $display("FAIL timeout: done=%b rc=%h gap=%0d required 1 %h 16",
                     t_done, t_rc, t_dcyc - t_wcyc, e_rc);
        end
        i_wrsp_v = 1'b1;
        i_wrsp_rc = 8'h77;
        tick();
        i_wrsp_v = 1'b0;
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_put_done_v !== 1'b0) begin
            bad++;
            $display("FAIL late_wrsp: busy=%b v=%b required 0 0", o_busy, o_put_done_v);
        end
        tick();
        exp_rc.push_back(8'h00);
        exp_wr_count++;
        run_txn(64'h6100, 10'h009, 1'b0, 1'b0, D_5, D_A, 2, -1, 1'b1, 8'h00,
                t_wr, t_ea, t_d, t_tag, t_wcyc, t_done, t_rc, t_dcyc);
        e_rc = exp_rc.pop_front();
        total++;
        if (!t_done || t_rc !== e_rc) begin
            bad++;
            $display("FAIL after_timeout: rc=%h required %h", t_rc, e_rc);
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic got;
        got = 1'b0;
        exp_wr_count++;
        drive_addr(64'h7000, 10'h00a, 1'b0, 1'b0);
        drive_beat(D_A, 1'b0, 1'b0);
        drive_beat(D_5, 1'b1, 1'b0);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = o_wr_v;
            tick();
        end
        repeat (3) tick();
        @(negedge clk);
        total++;
        if (!got || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_wait: wr=%b busy=%b required 1 1", got, o_busy);
        end
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({i_put_addr_r, i_put_data_r, o_wr_v, o_put_done_v, o_perror, o_busy} !== 6'b0 ||
            o_wr_ea !== 64'h0 || o_put_done_rc !== 8'h0) begin
            bad++;
            $display("FAIL mid_reset: flags=%b ea=%h required 0",
                     {i_put_addr_r, i_put_data_r, o_wr_v, o_put_done_v, o_perror, o_busy}, o_wr_ea);
        end
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (o_put_done_v !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_done: v=%b busy=%b required 0 0", o_put_done_v, o_busy);
        end
        tick();
        exp_rc.push_back(8'h00);
        exp_wr_count++;
        run_txn(64'h7100, 10'h00b, 1'b1, 1'b0, D_A, D_5, 2, -1, 1'b1, 8'h00,
                t_wr, t_ea, t_d, t_tag, t_wcyc, t_done, t_rc, t_dcyc);
        e_rc = exp_rc.pop_front();
        total++;
        if (!t_wr || !t_done || t_rc !== e_rc || t_ea !== 64'h7100) begin
            bad++;
            $display("FAIL after_reset: rc=%h ea=%h required %h 7100", t_rc, t_ea, e_rc);
        end
    endtask

    initial begin
        test_reset();
        test_good_write();
        test_data_parity();
        test_perror_sticky();
        test_proto();
        test_host_rc_backpressure();
`ifdef KTMS_PUT_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        repeat (2) tick();
        total++;
        if (wr_count != exp_wr_count || exp_rc.size() != 0) begin
            bad++;
            $display("FAIL write_total: got %0d required %0d (rc left %0d)",
                     wr_count, exp_wr_count, exp_rc.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
